uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter clk_freq, default 1000000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter baud_rate, default 9600, meaning the line bit rate in bits per second.
REQ-003 The block SHALL have parameter parity_mode, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-low (0 = in reset).
REQ-006 The block SHALL have port newd, input, 1 bit, the request to send txdata.
REQ-007 The block SHALL have port txdata, input, 8 bits, the byte to transmit.
REQ-008 The block SHALL have port tx, output, 1 bit, the serial line, idle high.
REQ-009 The block SHALL have port ready, output, 1 bit, high when a new byte can be accepted.
REQ-010 The block SHALL have port donetx, output, 1 bit, a one-cycle pulse marking frame completion.

Function
REQ-011 The block SHALL define bit period clk_count = clk_freq/baud_rate (integer division), in clk cycles; clk_count < 2 SHALL be a compile-time error.
REQ-012 The block SHALL time bit periods with a cycle counter in the clk domain; no derived or divided clock is used.
REQ-013 The block SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when parity_mode = 0.
REQ-014 ready SHALL be 1 exactly when the state is IDLE.
REQ-015 Acceptance SHALL occur on a rising edge where ready = 1 and newd = 1; txdata SHALL be captured into an internal shift register at that edge.
REQ-016 After acceptance, the block SHALL ignore changes on txdata, and SHALL ignore newd while ready = 0 (not queued, no error).
REQ-017 tx SHALL be registered; from the cycle after acceptance it SHALL drive the start bit 0 for clk_count cycles.
REQ-018 The block SHALL then drive the 8 data bits LSB first, each for clk_count cycles, using a 3-bit bit index that wraps 7 -> exit DATA.
REQ-019 With parity enabled, the block SHALL drive the parity bit for clk_count cycles: even -> XOR of the 8 data bits; odd -> its inverse.
REQ-020 The block SHALL drive the stop bit 1 for clk_count cycles; exactly one stop bit is used.
REQ-021 donetx SHALL be 1 for exactly the last clk cycle of the stop bit and 0 otherwise.
REQ-022 The state SHALL return to IDLE on the cycle after the last stop-bit cycle; ready rises then.
REQ-023 Frame length from the first start-bit cycle to the last stop-bit cycle SHALL be 10*clk_count cycles (11*clk_count with parity).
REQ-024 If newd is held high, back-to-back frames SHALL be separated by exactly one idle-high cycle (the IDLE acceptance cycle).
REQ-025 In IDLE, tx SHALL be 1.
REQ-026 The bit counter SHALL reset to 0 at every bit boundary; no bit may be shortened or stretched.

Reset
REQ-027 While rst = 0, the block SHALL hold tx = 1, ready = 0, donetx = 0, state = IDLE, and all counters and the shift register at 0, asynchronously.
REQ-028 After rst deasserts, ready SHALL be 1 from the first rising edge onward.
REQ-029 A reset mid-frame SHALL abort the frame immediately with tx = 1, with no partial donetx.
REQ-030 A newd sampled on the first edge after reset release SHALL be accepted.

Verification (clk_freq = 1000000, baud_rate = 100000, so clk_count = 10)
REQ-031 Scenario: parity_mode = 0, send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles; donetx pulses once at cycle 100 after acceptance; ready returns at cycle 101.
REQ-032 Scenario: parity_mode = 1, send 0x07 -> parity bit 1; parity_mode = 2, send 0x07 -> parity bit 0; frame is 110 cycles.
REQ-033 Scenario: newd pulsed with 0xFF mid-frame of 0x00 -> 0xFF is never transmitted; the 0x00 frame is unchanged and txdata changes do not alter the output.
REQ-034 Scenario: newd held high with 0xA5 then 0x3C -> two correct frames, one idle-high cycle between them, two donetx pulses.
REQ-035 Scenario: rst asserted during data bit 3 -> tx = 1 and ready = 0 immediately; no donetx; the next send of 0x81 after release is correct.
REQ-036 Scenario: loopback of tx into an independent bit-accurate reference receiver for 256 random bytes -> all bytes match.

Source files
------------

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Bit timing comes from a cycle counter in the clk domain; all outputs are registered.
module uart_tx #(
    parameter int clk_freq    = 1000000,
    parameter int baud_rate   = 9600,
    parameter int parity_mode = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic [7:0] txdata,
    output logic       tx,
    output logic       ready,
    output logic       donetx
);

    localparam int CLK_COUNT = clk_freq / baud_rate;
    localparam int CW        = (CLK_COUNT < 2) ? 1 : $clog2(CLK_COUNT);
    localparam logic [CW-1:0] LAST = CW'(CLK_COUNT - 1);
    localparam logic ODD_PARITY    = (parity_mode == 2);

    generate
        if (CLK_COUNT < 2) begin : g_bad_rate
            $error("uart_tx: clk_freq/baud_rate must be at least 2");
        end
        if (parity_mode < 0 || parity_mode > 2) begin : g_bad_parity
            $error("uart_tx: parity_mode must be 0, 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    logic bit_end;
    logic parity_bit;

    assign bit_end    = (cnt_q == LAST);
    assign parity_bit = (^shift_q) ^ ODD_PARITY;

    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                tx_d      = 1'b1;
                if (newd) begin
                    state_d = START;
                    shift_d = txdata;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    // Index wraps 7 -> 0 on the way out of DATA
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        if (parity_mode != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        // Outputs are registered, so decode them from the next state
        ready_d = (state_d == IDLE);
        done_d  = (state_d == STOP) && (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign tx     = tx_q;
    assign ready  = ready_q;
    assign donetx = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no/even/odd parity) checked cycle by cycle against
// a frame model built from the bit rules, plus a sampling receiver looped back on instance 0.
module tb_uart_tx;

    localparam int CC = 10;

    logic       clk;
    logic       rst;
    logic [2:0] newd;
    logic [7:0] txdata [3];
    logic [2:0] tx_o;
    logic [2:0] ready_o;
    logic [2:0] done_o;

    int checks = 0;
    int errors = 0;

    logic [8:0] rx_q [$];
    logic [7:0] sent_q [$];

    uart_tx #(.clk_freq(1000000), .baud_rate(100000), .parity_mode(0)) u_tx0 (
        .clk(clk), .rst(rst), .newd(newd[0]), .txdata(txdata[0]),
        .tx(tx_o[0]), .ready(ready_o[0]), .donetx(done_o[0]));
    uart_tx #(.clk_freq(1000000), .baud_rate(100000), .parity_mode(1)) u_tx1 (
        .clk(clk), .rst(rst), .newd(newd[1]), .txdata(txdata[1]),
        .tx(tx_o[1]), .ready(ready_o[1]), .donetx(done_o[1]));
    uart_tx #(.clk_freq(1000000), .baud_rate(100000), .parity_mode(2)) u_tx2 (
        .clk(clk), .rst(rst), .newd(newd[2]), .txdata(txdata[2]),
        .tx(tx_o[2]), .ready(ready_o[2]), .donetx(done_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent receiver: find the start edge, then sample mid-bit every CC cycles.
    initial begin : rx_model
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx_o[0] === 1'b0) begin
                repeat (CC / 2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CC) @(negedge clk);
                    b[i] = tx_o[0];
                end
                repeat (CC) @(negedge clk);
                stop_bit = tx_o[0];
                rx_q.push_back({stop_bit, b});
            end
        end
    end

    // Caller has already driven newd[m]=1 and txdata[m]=d at a negedge with the DUT idle.
    task automatic run_frame(input int m, input logic [7:0] d, input bit disturb,
                             input bit keep, input logic [7:0] nxt);
        int   nb;
        int   len;
        logic fr [11];
        logic exp_tx;
        nb  = (m != 0) ? 11 : 10;
        len = nb * CC;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i + 1] = d[i];
        if (m != 0) fr[9] = (^d) ^ (m == 2);
        fr[nb - 1] = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j <= len; j++) begin
            exp_tx = (j < len) ? fr[j / CC] : 1'b1;
            check($sformatf("m%0d d%02h tx j%0d", m, d, j), 32'(tx_o[m]), 32'(exp_tx));
            check($sformatf("m%0d d%02h donetx j%0d", m, d, j), 32'(done_o[m]), 32'(j == len - 1));
            check($sformatf("m%0d d%02h ready j%0d", m, d, j), 32'(ready_o[m]), 32'(j == len));
            if (j == len) break;
            @(negedge clk);
            if (keep) begin
                newd[m]   = 1'b1;
                txdata[m] = nxt;
            end else if (disturb) begin
                newd[m]   = 1'($urandom_range(0, 1));
                txdata[m] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            end else begin
                newd[m]   = 1'b0;
                txdata[m] = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        if (!keep) begin
            @(negedge clk);
            newd[m] = 1'b0;
            @(posedge clk); #1;
            check($sformatf("m%0d d%02h idle ready", m, d), 32'(ready_o[m]), 32'd1);
            check($sformatf("m%0d d%02h idle tx", m, d), 32'(tx_o[m]), 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin : stim
        logic [7:0] d;
        rst  = 1'b1;
        newd = 3'b000;
        for (int m = 0; m < 3; m++) txdata[m] = 8'h00;

        // Reset state
        #1 rst = 1'b0;
        #2;
        for (int m = 0; m < 3; m++) begin
            check($sformatf("m%0d reset tx", m), 32'(tx_o[m]), 32'd1);
            check($sformatf("m%0d reset ready", m), 32'(ready_o[m]), 32'd0);
            check($sformatf("m%0d reset donetx", m), 32'(done_o[m]), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 check("reset held ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready after release", 32'(ready_o), 32'h7);
        check("tx after release", 32'(tx_o), 32'h7);
        @(negedge clk);

        // Plain frame, no parity
        newd[0] = 1'b1; txdata[0] = 8'h55;
        run_frame(0, 8'h55, 1'b0, 1'b0, 8'h00);

        // Parity frames, fixed then random bytes
        newd[1] = 1'b1; txdata[1] = 8'h07;
        run_frame(1, 8'h07, 1'b0, 1'b0, 8'h00);
        newd[2] = 1'b1; txdata[2] = 8'h07;
        run_frame(2, 8'h07, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            for (int m = 1; m < 3; m++) begin
                d = 8'($urandom);
                newd[m] = 1'b1; txdata[m] = d;
                run_frame(m, d, k[0], 1'b0, 8'h00);
            end
        end

        // newd and txdata churn mid-frame must not disturb the frame in flight
        newd[0] = 1'b1; txdata[0] = 8'h00;
        run_frame(0, 8'h00, 1'b1, 1'b0, 8'h00);

        // newd held high: back-to-back frames with a single idle cycle between
        newd[0] = 1'b1; txdata[0] = 8'hA5;
        run_frame(0, 8'hA5, 1'b0, 1'b1, 8'h3C);
        run_frame(0, 8'h3C, 1'b0, 1'b0, 8'h00);

        // Reset during data bit 3
        newd[0] = 1'b1; txdata[0] = 8'h6B;
        @(posedge clk); #1;
        check("abort accepted", 32'(ready_o[0]), 32'd0);
        @(negedge clk);
        newd[0] = 1'b0;
        repeat (CC + 3 * CC + 4 - 1) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("abort tx", 32'(tx_o[0]), 32'd1);
        check("abort ready", 32'(ready_o[0]), 32'd0);
        check("abort donetx", 32'(done_o[0]), 32'd0);
        for (int j = 0; j < 12 * CC; j++) begin
            @(posedge clk); #1;
            check($sformatf("in reset tx c%0d", j), 32'(tx_o[0]), 32'd1);
            check($sformatf("in reset ready c%0d", j), 32'(ready_o[0]), 32'd0);
            check($sformatf("in reset donetx c%0d", j), 32'(done_o[0]), 32'd0);
        end
        @(negedge clk);
        newd[0] = 1'b1; txdata[0] = 8'h81;
        rst = 1'b1;
        run_frame(0, 8'h81, 1'b0, 1'b0, 8'h00);

        // Loopback through the reference receiver
        repeat (20) @(negedge clk);
        rx_q.delete();
        for (int k = 0; k < 256; k++) begin
            d = 8'($urandom);
            sent_q.push_back(d);
            newd[0] = 1'b1; txdata[0] = d;
            run_frame(0, d, 1'b0, 1'b0, 8'h00);
        end
        repeat (20) @(negedge clk);
        check("loopback count", 32'(rx_q.size()), 32'd256);
        for (int k = 0; k < 256 && k < rx_q.size(); k++)
            check($sformatf("loopback byte %0d", k), 32'(rx_q[k]), 32'({1'b1, sent_q[k]}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
